// File: rtl/text_buffer_pkg.sv
// Shared constants for the text-mode character store: host opcodes, default
// geometry, fill FSM states and the CHARATTR field layout used by the renderer.
package text_buffer_pkg;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 30;
  localparam int DEF_ATTR_W = 32;

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_WRITE       = 3'd1,
    OP_READ        = 3'd2,
    OP_CLEAR       = 3'd3,
    OP_SCROLL_UP   = 3'd4,
    OP_SCROLL_DOWN = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL_ALL,
    ST_FILL_ROW
  } fill_state_e;

  // CHARATTR bit ranges as decoded by the character renderer
  localparam int CA_INDEX_LSB = 0;
  localparam int CA_INDEX_MSB = 7;
  localparam int CA_FG_LSB    = 8;
  localparam int CA_FG_MSB    = 15;
  localparam int CA_BG_LSB    = 16;
  localparam int CA_BG_MSB    = 23;
  localparam int CA_SIZE_LSB  = 24;
  localparam int CA_SIZE_MSB  = 25;
  localparam int CA_PART_LSB  = 26;
  localparam int CA_PART_MSB  = 27;
  localparam int CA_BLINK     = 28;
  localparam int CA_ULINE     = 29;

  function automatic logic [7:0] ca_index(input logic [DEF_ATTR_W-1:0] attr);
    return attr[CA_INDEX_MSB:CA_INDEX_LSB];
  endfunction

endpackage

// File: rtl/text_buffer_if.sv
// Host command / read-back bundle of the text buffer; the host side uses
// master, the buffer uses slave.
interface text_buffer_if #(
  parameter int XW     = $clog2(text_buffer_pkg::DEF_COLS),
  parameter int YW     = $clog2(text_buffer_pkg::DEF_ROWS),
  parameter int ATTR_W = text_buffer_pkg::DEF_ATTR_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [XW-1:0]     cmd_x;
  logic [YW-1:0]     cmd_y;
  logic [ATTR_W-1:0] cmd_data;
  logic              rd_valid;
  logic [ATTR_W-1:0] rd_data;
  logic              busy;
  logic [YW-1:0]     row_offset;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    input  cmd_ready, rd_valid, rd_data, busy, row_offset
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    output cmd_ready, rd_valid, rd_data, busy, row_offset
  );

endinterface

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell store: one write port, one synchronous read port with
// read-before-write behaviour, written for block-RAM inference.
module text_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [0:DEPTH-1];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_buffer.sv
// Text-mode character/attribute store: display read port with hardware
// vertical scroll, host command port and a one-cell-per-cycle fill engine.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ATTR_W = DEF_ATTR_W,
  parameter int XW     = $clog2(COLS),
  parameter int YW     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_char,
  input  logic [XW-1:0]     xtext,
  input  logic [YW-1:0]     ytext,
  output logic [ATTR_W-1:0] charattr,
  text_buffer_if.slave      host
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [AW-1:0] LAST_ALL = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(COLS - 1);
  localparam logic [YW:0]   ROWS_P   = (YW + 1)'(ROWS);
  localparam logic [YW-1:0] ROW_MAX  = YW'(ROWS - 1);

  // Logical row is rotated by the scroll offset; sum stays below 2*ROWS.
  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y,
                                              input logic [YW-1:0] off);
    logic [YW:0] phys;
    phys = {1'b0, y} + {1'b0, off};
    if (phys >= ROWS_P) begin
      phys = phys - ROWS_P;
    end
    return AW'(phys) * COLS_A + AW'(x);
  endfunction

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) < COLS) && (int'(y) < ROWS);
  endfunction

  fill_state_e       state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     base_q, base_d;
  logic [ATTR_W-1:0] fill_q, fill_d;
  logic [YW-1:0]     off_q, off_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_ok_q, rd_ok_d;
  logic              disp_ok_q, disp_ok_d;

  logic              disp_ok, host_ok, host_re;
  logic [AW-1:0]     disp_addr, host_addr;
  logic [YW-1:0]     off_inc, off_dec;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [ATTR_W-1:0] ram_wdata;
  logic [ATTR_W-1:0] disp_word, host_word;

  assign disp_ok   = in_range(xtext, ytext);
  assign disp_addr = cell_addr(xtext, ytext, off_q);
  assign host_ok   = in_range(host.cmd_x, host.cmd_y);
  assign host_addr = cell_addr(host.cmd_x, host.cmd_y, off_q);
  assign off_inc   = (off_q == ROW_MAX) ? '0 : off_q + YW'(1);
  assign off_dec   = (off_q == '0) ? ROW_MAX : off_q - YW'(1);
  assign disp_ok_d = load_char ? disp_ok : disp_ok_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    fill_d     = fill_q;
    off_d      = off_q;
    rd_valid_d = 1'b0;
    rd_ok_d    = rd_ok_q;
    host_re    = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = base_q + cnt_q;
    ram_wdata  = fill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          case (host.cmd_op)
            OP_WRITE: begin
              ram_we    = host_ok;
              ram_waddr = host_addr;
              ram_wdata = host.cmd_data;
            end
            OP_READ: begin
              rd_valid_d = 1'b1;
              rd_ok_d    = host_ok;
              host_re    = host_ok;
            end
            OP_CLEAR: begin
              off_d   = '0;
              base_d  = '0;
              cnt_d   = '0;
              fill_d  = host.cmd_data;
              state_d = ST_FILL_ALL;
            end
            // The row leaving the top becomes the new bottom row.
            OP_SCROLL_UP: begin
              off_d   = off_inc;
              base_d  = AW'(off_q) * COLS_A;
              cnt_d   = '0;
              fill_d  = host.cmd_data;
              state_d = ST_FILL_ROW;
            end
            OP_SCROLL_DOWN: begin
              off_d   = off_dec;
              base_d  = AW'(off_dec) * COLS_A;
              cnt_d   = '0;
              fill_d  = host.cmd_data;
              state_d = ST_FILL_ROW;
            end
            default: ;
          endcase
        end
      end
      ST_FILL_ALL, ST_FILL_ROW: begin
        ram_we = 1'b1;
        if (cnt_q == ((state_q == ST_FILL_ALL) ? LAST_ALL : LAST_ROW)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      fill_q     <= '0;
      off_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      disp_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      fill_q     <= fill_d;
      off_q      <= off_d;
      rd_valid_q <= rd_valid_d;
      rd_ok_q    <= rd_ok_d;
      disp_ok_q  <= disp_ok_d;
    end
  end

  // Two copies share every write so display and host reads never contend.
  text_ram #(.DEPTH(DEPTH), .AW(AW), .W(ATTR_W)) u_disp_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (load_char && disp_ok),
    .raddr_i (disp_addr),
    .rdata_o (disp_word)
  );

  text_ram #(.DEPTH(DEPTH), .AW(AW), .W(ATTR_W)) u_host_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (host_re),
    .raddr_i (host_addr),
    .rdata_o (host_word)
  );

  assign charattr        = disp_ok_q ? disp_word : '0;
  assign host.rd_data    = rd_ok_q ? host_word : '0;
  assign host.rd_valid   = rd_valid_q;
  assign host.cmd_ready  = (state_q == ST_IDLE);
  assign host.busy       = (state_q != ST_IDLE);
  assign host.row_offset = off_q;

endmodule
